// File: rtl/pim_sparsity_gate_ooo.sv
// Sparsity-aware AXI read gate: sparse window blocks are answered locally with zero bursts, in request order.
// Optional PIM_ZVC_AUTOLEARN_EN: all-zero dense single-block bursts mark their block sparse at pop.
module pim_sparsity_gate_ooo #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned NUM_BLOCKS      = 4096,
  parameter int unsigned BLOCK_BYTES     = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     cfg_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_limit,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_BLOCKS)-1:0] cfg_idx,
  input  logic                      cfg_dense,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      s_axi_ruser,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [31:0]               sparse_req_cnt,
  output logic [31:0]               dense_req_cnt,
  output logic [31:0]               zero_beat_cnt
);

  localparam int unsigned IDX_W     = $clog2(NUM_BLOCKS);
  localparam int unsigned OFF_SHIFT = $clog2(BLOCK_BYTES);
  localparam int unsigned PTR_W     = $clog2(MAX_OUTSTANDING);
  localparam int unsigned AW1       = ADDR_WIDTH + 1;

  typedef struct packed {
    logic                sparse;
    logic [ID_WIDTH-1:0] id;
    logic [7:0]          len;
`ifdef PIM_ZVC_AUTOLEARN_EN
    logic                learn;
    logic [IDX_W-1:0]    idx;
`endif
  } q_entry_t;

  logic [NUM_BLOCKS-1:0] meta, meta_nxt;
  q_entry_t              q_mem [MAX_OUTSTANDING];
  q_entry_t              head, push_entry;
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [7:0]            beat_cnt;
  logic                  empty, full;

  // Write channels pass straight through
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awvalid = s_axi_awvalid;
  assign s_axi_awready = m_axi_awready;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wvalid  = s_axi_wvalid;
  assign s_axi_wready  = m_axi_wready;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;

  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;

  // Read classification: block index, window test, single-block test
  logic [ADDR_WIDTH-1:0] ar_off, ar_blk, aw_off, aw_blk;
  logic [AW1-1:0]        ar_bytes;
  logic                  ar_in_win, ar_same_blk, ar_sparse, aw_in_win;
  logic [IDX_W-1:0]      ar_idx, aw_idx;

  assign ar_off      = s_axi_araddr - cfg_base;
  assign ar_blk      = ar_off >> OFF_SHIFT;
  assign ar_idx      = ar_blk[IDX_W-1:0];
  assign ar_in_win   = (s_axi_araddr >= cfg_base) && (s_axi_araddr < cfg_limit) &&
                       (ar_blk < ADDR_WIDTH'(NUM_BLOCKS));
  assign ar_bytes    = (AW1'(s_axi_arlen) + AW1'(1)) << s_axi_arsize;
  assign ar_same_blk = (AW1'(ar_off[OFF_SHIFT-1:0]) + ar_bytes) <= AW1'(BLOCK_BYTES);
  assign ar_sparse   = ar_in_win && !meta[ar_idx] && ar_same_blk;

  assign aw_off    = s_axi_awaddr - cfg_base;
  assign aw_blk    = aw_off >> OFF_SHIFT;
  assign aw_idx    = aw_blk[IDX_W-1:0];
  assign aw_in_win = (s_axi_awaddr >= cfg_base) && (s_axi_awaddr < cfg_limit) &&
                     (aw_blk < ADDR_WIDTH'(NUM_BLOCKS));

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr - rd_ptr) == (PTR_W+1)'(MAX_OUTSTANDING));
  assign head  = q_mem[rd_ptr[PTR_W-1:0]];

  assign m_axi_arvalid = s_axi_arvalid && !ar_sparse && !full;
  assign s_axi_arready = !full && (ar_sparse || m_axi_arready);

  logic ar_fire, r_fire, pop, zero_fire, aw_fire;
  assign ar_fire   = s_axi_arvalid && s_axi_arready;
  assign r_fire    = s_axi_rvalid && s_axi_rready;
  assign pop       = r_fire && s_axi_rlast;
  assign zero_fire = r_fire && head.sparse;
  assign aw_fire   = s_axi_awvalid && m_axi_awready;

  always_comb begin
    push_entry        = '0;
    push_entry.sparse = ar_sparse;
    push_entry.id     = s_axi_arid;
    push_entry.len    = s_axi_arlen;
`ifdef PIM_ZVC_AUTOLEARN_EN
    push_entry.learn  = ar_in_win && ar_same_blk;
    push_entry.idx    = ar_idx;
`endif
  end

  // Response mux driven by the queue head
  always_comb begin
    s_axi_rvalid = 1'b0;
    s_axi_rid    = '0;
    s_axi_rdata  = '0;
    s_axi_rresp  = 2'b00;
    s_axi_rlast  = 1'b0;
    s_axi_ruser  = 1'b0;
    m_axi_rready = 1'b0;
    if (!empty) begin
      if (head.sparse) begin
        s_axi_rvalid = 1'b1;
        s_axi_rid    = head.id;
        s_axi_rlast  = (beat_cnt == head.len);
        s_axi_ruser  = 1'b1;
      end else begin
        s_axi_rvalid = m_axi_rvalid;
        s_axi_rid    = m_axi_rid;
        s_axi_rdata  = m_axi_rdata;
        s_axi_rresp  = m_axi_rresp;
        s_axi_rlast  = m_axi_rlast;
        m_axi_rready = s_axi_rready;
      end
    end
  end

`ifdef PIM_ZVC_AUTOLEARN_EN
  logic zero_acc, learn_clr;
  assign learn_clr = pop && !head.sparse && head.learn && zero_acc && (m_axi_rdata == '0);
`endif

  // Later assignments win: cfg_we over AW invalidation over learning
  always_comb begin
    meta_nxt = meta;
`ifdef PIM_ZVC_AUTOLEARN_EN
    if (learn_clr) meta_nxt[head.idx] = 1'b0;
`endif
    if (aw_fire && aw_in_win) meta_nxt[aw_idx] = 1'b1;
    if (cfg_we) meta_nxt[cfg_idx] = cfg_dense;
  end

  always_ff @(posedge clk) begin
    if (ar_fire) q_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta           <= '1;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      beat_cnt       <= '0;
      sparse_req_cnt <= '0;
      dense_req_cnt  <= '0;
      zero_beat_cnt  <= '0;
    end else begin
      meta <= meta_nxt;
      if (ar_fire) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        if (ar_sparse) sparse_req_cnt <= sparse_req_cnt + 32'd1;
        else           dense_req_cnt  <= dense_req_cnt + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (zero_fire) begin
        beat_cnt      <= s_axi_rlast ? 8'd0 : beat_cnt + 8'd1;
        zero_beat_cnt <= zero_beat_cnt + 32'd1;
      end
    end
  end

`ifdef PIM_ZVC_AUTOLEARN_EN
  // Tracks whether every beat of the current dense head burst has been zero
  always_ff @(posedge clk) begin
    if (rst) zero_acc <= 1'b1;
    else if (r_fire && !head.sparse) zero_acc <= s_axi_rlast ? 1'b1 : (zero_acc && (m_axi_rdata == '0));
  end
`endif

endmodule

// File: tb/tb_pim_sparsity_gate_ooo.sv
// Directed bench for pim_sparsity_gate_ooo with an in-order R-beat scoreboard.
module tb_pim_sparsity_gate_ooo;
  localparam int unsigned DW = 512;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] cfg_base, cfg_limit;
  logic        cfg_we, cfg_dense;
  logic [11:0] cfg_idx;
  logic [7:0]  s_axi_arid, s_axi_arlen, s_axi_rid, m_axi_arid, m_axi_arlen, m_axi_rid;
  logic [31:0] s_axi_araddr, m_axi_araddr;
  logic [2:0]  s_axi_arsize, m_axi_arsize;
  logic [1:0]  s_axi_arburst, m_axi_arburst, s_axi_rresp, m_axi_rresp;
  logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] s_axi_rdata, m_axi_rdata;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready, s_axi_ruser;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [7:0]  s_axi_awid, s_axi_awlen, m_axi_awid, m_axi_awlen, s_axi_bid, m_axi_bid;
  logic [31:0] s_axi_awaddr, m_axi_awaddr;
  logic [2:0]  s_axi_awsize, m_axi_awsize;
  logic [1:0]  s_axi_awburst, m_axi_awburst, s_axi_bresp, m_axi_bresp;
  logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   s_axi_wdata, m_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb, m_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic [31:0] sparse_req_cnt, dense_req_cnt, zero_beat_cnt;

  pim_sparsity_gate_ooo dut (
    .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_dense(cfg_dense),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .s_axi_ruser(s_axi_ruser),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .sparse_req_cnt(sparse_req_cnt), .dense_req_cnt(dense_req_cnt), .zero_beat_cnt(zero_beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    id;
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_sparse_n = 0, exp_dense_n = 0, exp_zero_n = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int id, input int b, input bit zero);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(id * 256 + b);
    return zero ? '0 : {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every s_axi R handshake must match the oldest expected beat
  always @(negedge clk) begin
    if (!rst && s_axi_rvalid && s_axi_rready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", {504'd0, s_axi_rid}, '1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("r_id", DW'(s_axi_rid), DW'(e.id));
        check("r_data", s_axi_rdata, e.data);
        check("r_user", DW'(s_axi_ruser), DW'(e.user));
        check("r_last", DW'(s_axi_rlast), DW'(e.last));
        check("r_resp", DW'(s_axi_rresp), '0);
      end
    end
  end

  task automatic push_exp(input int id, input int len, input bit sparse, input bit zero);
    for (int b = 0; b <= len; b++) begin
      exp_t e;
      e.id = 8'(id);
      e.data = pat(id, b, sparse || zero);
      e.user = sparse;
      e.last = (b == len);
      sb.push_back(e);
    end
    if (sparse) begin
      exp_sparse_n++;
      exp_zero_n += len + 1;
    end else begin
      exp_dense_n++;
    end
  endtask

  task automatic ar(input logic [31:0] addr, input int len, input int size, input int id,
                    input bit exp_sparse, input bit zero);
    s_axi_araddr = addr;
    s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size);
    s_axi_arid = 8'(id);
    s_axi_arvalid = 1'b1;
    #1;
    check("ar_arready", DW'(s_axi_arready), DW'(1));
    check("ar_m_arvalid", DW'(m_axi_arvalid), DW'(!exp_sparse));
    tick();
    s_axi_arvalid = 1'b0;
    push_exp(id, len, exp_sparse, zero);
  endtask

  task automatic mem_reply(input int id, input int len, input bit zero);
    for (int b = 0; b <= len; b++) begin
      int t = 0;
      m_axi_rvalid = 1'b1;
      m_axi_rid = 8'(id);
      m_axi_rdata = pat(id, b, zero);
      m_axi_rlast = (b == len);
      m_axi_rresp = 2'b00;
      #1;
      while (!m_axi_rready && t < 100) begin
        tick();
        t++;
      end
      check("mem_rready", DW'(m_axi_rready), DW'(1));
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain_sb_empty", DW'(sb.size()), '0);
  endtask

  task automatic cfg_write(input int idx, input bit dense);
    cfg_we = 1'b1;
    cfg_idx = 12'(idx);
    cfg_dense = dense;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_base = 32'h0001_0000;
    cfg_limit = 32'h0002_0000;
    cfg_we = 1'b0; cfg_idx = '0; cfg_dense = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd4;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    m_axi_arready = 1'b1; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd4;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; m_axi_awready = 1'b1;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    m_axi_wready = 1'b1; s_axi_bready = 1'b1; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_bvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_rvalid", DW'(s_axi_rvalid), '0);
    check("rst_m_arvalid", DW'(m_axi_arvalid), '0);
    check("rst_sparse_cnt", DW'(sparse_req_cnt), '0);
    check("rst_dense_cnt", DW'(dense_req_cnt), '0);
    check("rst_zero_cnt", DW'(zero_beat_cnt), '0);

    // T1: dense read forwarded, memory beats pass through
    ar(32'h0001_0000, 3, 4, 1, 1'b0, 1'b0);
    mem_reply(1, 3, 1'b0);
    drain();
    check("t1_dense_cnt", DW'(dense_req_cnt), DW'(1));

    // T2: sparse read answered locally, 1-cycle latency, stable under stall
    cfg_write(0, 1'b0);
    s_axi_rready = 1'b0;
    ar(32'h0001_0000, 3, 4, 5, 1'b1, 1'b0);
    check("t2_first_rvalid", DW'(s_axi_rvalid), DW'(1));
    check("t2_stall_rid", DW'(s_axi_rid), DW'(5));
    tick();
    check("t2_stall_rvalid", DW'(s_axi_rvalid), DW'(1));
    check("t2_stall_rlast", DW'(s_axi_rlast), '0);
    check("t2_stall_ruser", DW'(s_axi_ruser), DW'(1));
    s_axi_rready = 1'b1;
    drain();
    check("t2_zero_cnt", DW'(zero_beat_cnt), DW'(4));
    check("t2_sparse_cnt", DW'(sparse_req_cnt), DW'(1));

    // T3: dense then sparse back-to-back; sparse waits behind the slow memory burst
    ar(32'h0001_0040, 3, 4, 1, 1'b0, 1'b0);
    ar(32'h0001_0000, 1, 4, 2, 1'b1, 1'b0);
    repeat (10) tick();
    check("t3_wait_rvalid", DW'(s_axi_rvalid), '0);
    mem_reply(1, 3, 1'b0);
    drain();

    // T4: queue full blocks the 9th AR until the first pop
    for (int i = 0; i < 8; i++) ar(32'h0001_0100 + 32'(i * 64), 0, 4, 16 + i, 1'b0, 1'b0);
    s_axi_araddr = 32'h0001_0400; s_axi_arlen = 8'd0; s_axi_arid = 8'd30; s_axi_arvalid = 1'b1;
    #1;
    check("t4_full_arready", DW'(s_axi_arready), '0);
    check("t4_full_m_arvalid", DW'(m_axi_arvalid), '0);
    tick();
    m_axi_rvalid = 1'b1; m_axi_rid = 8'd16; m_axi_rdata = pat(16, 0, 1'b0); m_axi_rlast = 1'b1;
    #1;
    check("t4_prepop_arready", DW'(s_axi_arready), '0);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1;
    check("t4_postpop_arready", DW'(s_axi_arready), DW'(1));
    check("t4_postpop_m_arvalid", DW'(m_axi_arvalid), DW'(1));
    tick();
    s_axi_arvalid = 1'b0;
    push_exp(30, 0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) mem_reply(16 + i, 0, 1'b0);
    mem_reply(30, 0, 1'b0);
    drain();
    check("t4_dense_cnt", DW'(dense_req_cnt), DW'(exp_dense_n));

    // T5: AW into sparse block 0 invalidates it
    s_axi_awaddr = 32'h0001_0010; s_axi_awvalid = 1'b1;
    #1;
    check("t5_m_awvalid", DW'(m_axi_awvalid), DW'(1));
    tick();
    s_axi_awvalid = 1'b0;
    ar(32'h0001_0000, 0, 4, 7, 1'b0, 1'b0);
    mem_reply(7, 0, 1'b0);
    drain();

    // Block-boundary: crossing into the next block is dense, an exact fit is sparse
    cfg_write(0, 1'b0);
    ar(32'h0001_0030, 1, 4, 8, 1'b0, 1'b0);
    mem_reply(8, 1, 1'b0);
    ar(32'h0001_0030, 0, 4, 9, 1'b1, 1'b0);
    drain();
    // Address at cfg_limit is outside the window
    cfg_limit = 32'h0001_0000;
    ar(32'h0001_0000, 0, 4, 13, 1'b0, 1'b0);
    mem_reply(13, 0, 1'b0);
    drain();
    cfg_limit = 32'h0002_0000;

    // T6: all-zero dense burst of idx2, then a repeat read
    ar(32'h0001_0080, 1, 4, 10, 1'b0, 1'b1);
    mem_reply(10, 1, 1'b1);
    drain();
`ifdef PIM_ZVC_AUTOLEARN_EN
    ar(32'h0001_0080, 1, 4, 11, 1'b1, 1'b0);
`else
    ar(32'h0001_0080, 1, 4, 11, 1'b0, 1'b1);
    mem_reply(11, 1, 1'b1);
`endif
    drain();
    check("fin_sparse_cnt", DW'(sparse_req_cnt), DW'(exp_sparse_n));
    check("fin_dense_cnt", DW'(dense_req_cnt), DW'(exp_dense_n));
    check("fin_zero_cnt", DW'(zero_beat_cnt), DW'(exp_zero_n));

    // Reset in the middle of a sparse burst flushes the queue
    s_axi_rready = 1'b0;
    ar(32'h0001_0000, 3, 4, 12, 1'b1, 1'b0);
    check("mid_rvalid_before", DW'(s_axi_rvalid), DW'(1));
    rst = 1'b1;
    tick();
    check("mid_rvalid_after", DW'(s_axi_rvalid), '0);
    check("mid_zero_cnt", DW'(zero_beat_cnt), '0);
    sb.delete();
    rst = 1'b0;
    s_axi_rready = 1'b1;
    tick();
    check("mid_idle_rvalid", DW'(s_axi_rvalid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
